// File: rtl/alu_rr_scheduler.sv
// Two-requester round-robin front end sharing one ALU, with a single-entry
// result register (valid/ready) and per-requester saturating grant counters.
module alu_rr_scheduler #(
  parameter int N     = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s0_valid,
  output logic             s0_ready,
  input  logic [2:0]       s0_op,
  input  logic [N-1:0]     s0_a,
  input  logic [N-1:0]     s0_b,
  input  logic             s1_valid,
  output logic             s1_ready,
  input  logic [2:0]       s1_op,
  input  logic [N-1:0]     s1_a,
  input  logic [N-1:0]     s1_b,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [N-1:0]     m_y,
  output logic [2:0]       m_op,
  output logic             m_src,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Shared ALU; every result is truncated to N bits.
  function automatic logic [N-1:0] alu_eval(input logic [2:0] op,
                                            input logic [N-1:0] a,
                                            input logic [N-1:0] b);
    logic [N-1:0] r;
    case (op)
      3'b000:  r = a + b;
      3'b001:  r = a - b;
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b100:  r = a ^ b;
      3'b101:  r = {a[N-2:0], 1'b0};
      3'b110:  r = {1'b0, a[N-1:1]};
      default: r = a;
    endcase
    return r;
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_ONE;
  endfunction

  logic             last_grant;
  logic             slot_free;
  logic             gnt_vld;
  logic             gnt_idx;
  logic             accept;
  logic [2:0]       sel_op;
  logic [N-1:0]     sel_a;
  logic [N-1:0]     sel_b;

  logic             vld_p1;
  logic [N-1:0]     y_p1;
  logic [2:0]       op_p1;
  logic             src_p1;
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  // Round-robin grant and operand select; readies are held low during reset
  // so no handshake can complete on a reset edge.
  always_comb begin
    slot_free = !vld_p1 || m_ready;
    gnt_vld   = s0_valid || s1_valid;
    if (s0_valid && s1_valid) gnt_idx = ~last_grant;
    else                      gnt_idx = s1_valid;
    s0_ready  = !rst && slot_free && gnt_vld && !gnt_idx;
    s1_ready  = !rst && slot_free && gnt_vld &&  gnt_idx;
    accept    = (s0_valid && s0_ready) || (s1_valid && s1_ready);
    sel_op    = gnt_idx ? s1_op : s0_op;
    sel_a     = gnt_idx ? s1_a  : s0_a;
    sel_b     = gnt_idx ? s1_b  : s0_b;
  end

  // ---- stage p1: result register, arbitration history, grant counters ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      y_p1       <= '0;
      op_p1      <= 3'b000;
      src_p1     <= 1'b0;
      last_grant <= 1'b1;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else if (accept) begin
      vld_p1     <= 1'b1;
      y_p1       <= alu_eval(sel_op, sel_a, sel_b);
      op_p1      <= sel_op;
      src_p1     <= gnt_idx;
      last_grant <= gnt_idx;
      if (gnt_idx) cnt1_q <= sat_inc(cnt1_q);
      else         cnt0_q <= sat_inc(cnt0_q);
    end else if (m_ready) begin
      vld_p1     <= 1'b0;
    end
  end

  assign m_valid = vld_p1;
  assign m_y     = y_p1;
  assign m_op    = op_p1;
  assign m_src   = src_p1;
  assign cnt0    = cnt0_q;
  assign cnt1    = cnt1_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler. A second instance with CNT_W=4 shares
// all inputs so counter saturation can be observed quickly.
module tb_alu_rr_scheduler;

  localparam int N = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s0_valid = 1'b0, s1_valid = 1'b0, m_ready = 1'b1;
  logic [2:0]    s0_op = 3'd0, s1_op = 3'd0;
  logic [N-1:0]  s0_a = '0, s0_b = '0, s1_a = '0, s1_b = '0;

  logic          s0_ready, s1_ready, m_valid, m_src;
  logic [N-1:0]  m_y;
  logic [2:0]    m_op;
  logic [15:0]   cnt0, cnt1;

  logic          s0_ready4, s1_ready4, m_valid4, m_src4;
  logic [N-1:0]  m_y4;
  logic [2:0]    m_op4;
  logic [3:0]    cnt0_4, cnt1_4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_rr_scheduler #(.N(N), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_op(s0_op), .s0_a(s0_a), .s0_b(s0_b),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_op(s1_op), .s1_a(s1_a), .s1_b(s1_b),
    .m_valid(m_valid), .m_ready(m_ready), .m_y(m_y), .m_op(m_op), .m_src(m_src),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  alu_rr_scheduler #(.N(N), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready4), .s0_op(s0_op), .s0_a(s0_a), .s0_b(s0_b),
    .s1_valid(s1_valid), .s1_ready(s1_ready4), .s1_op(s1_op), .s1_a(s1_a), .s1_b(s1_b),
    .m_valid(m_valid4), .m_ready(m_ready), .m_y(m_y4), .m_op(m_op4), .m_src(m_src4),
    .cnt0(cnt0_4), .cnt1(cnt1_4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s0_valid = 1'b0; s1_valid = 1'b0; m_ready = 1'b1; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    s0_valid = 1'b1; s1_valid = 1'b1; m_ready = 1'b1;
    s0_op = 3'b111; s0_a = 16'h0011; s1_op = 3'b111; s1_a = 16'h0022;
    rst = 1'b1;
    tick(); tick();
    n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    n_tests++; if (m_y !== 16'h0000) begin n_fail++; $display("FAIL reset_m_y got %h want 0000", m_y); end
    n_tests++; if (m_src !== 1'b0) begin n_fail++; $display("FAIL reset_m_src got %b want 0", m_src); end
    n_tests++; if (m_op !== 3'b000) begin n_fail++; $display("FAIL reset_m_op got %b want 000", m_op); end
    n_tests++; if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d want 0/0", cnt0, cnt1); end
    n_tests++; if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b%b want 00", s0_ready, s1_ready); end
    rst = 1'b0;
    #1;
    n_tests++; if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin n_fail++; $display("FAIL first_grant ready got %b%b want 10", s0_ready, s1_ready); end
    tick();
    n_tests++; if (m_valid !== 1'b1 || m_src !== 1'b0 || m_y !== 16'h0011) begin n_fail++; $display("FAIL first_grant result got v=%b src=%b y=%h want v=1 src=0 y=0011", m_valid, m_src, m_y); end
    s0_valid = 1'b0; s1_valid = 1'b0;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    s0_valid = 1'b1; s0_op = 3'b000; s0_a = 16'hFFFF; s0_b = 16'h0002;
    #1;
    n_tests++; if (s0_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got %b want 1", s0_ready); end
    tick();
    s0_valid = 1'b0;
    n_tests++; if (m_valid !== 1'b1 || m_y !== 16'h0001 || m_op !== 3'b000 || m_src !== 1'b0) begin
      n_fail++; $display("FAIL single_result got v=%b y=%h op=%b src=%b want v=1 y=0001 op=000 src=0", m_valid, m_y, m_op, m_src); end
    n_tests++; if (cnt0 !== 16'd1 || cnt1 !== 16'd0) begin n_fail++; $display("FAIL single_cnt got %0d/%0d want 1/0", cnt0, cnt1); end
    tick();
    n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got %b want 0", m_valid); end
  endtask

  task automatic test_opsweep();
    logic [N-1:0] exp_y [8];
    exp_y[0] = 16'h80F1; exp_y[1] = 16'h7F11; exp_y[2] = 16'h0000; exp_y[3] = 16'h80F1;
    exp_y[4] = 16'h80F1; exp_y[5] = 16'h0002; exp_y[6] = 16'h4000; exp_y[7] = 16'h8001;
    do_reset();
    s1_valid = 1'b1; s1_a = 16'h8001; s1_b = 16'h00F0;
    for (int i = 0; i < 8; i++) begin
      s1_op = 3'(i);
      tick();
      n_tests++; if (m_valid !== 1'b1 || m_y !== exp_y[i] || m_op !== 3'(i) || m_src !== 1'b1) begin
        n_fail++; $display("FAIL opsweep_%0d got v=%b y=%h op=%b src=%b want v=1 y=%h op=%b src=1", i, m_valid, m_y, m_op, m_src, exp_y[i], 3'(i)); end
    end
    s1_valid = 1'b0;
    n_tests++; if (cnt1 !== 16'd8 || cnt0 !== 16'd0) begin n_fail++; $display("FAIL opsweep_cnt got %0d/%0d want 0/8", cnt0, cnt1); end
    tick();
  endtask

  task automatic test_contention();
    logic exp_src;
    do_reset();
    s0_valid = 1'b1; s0_op = 3'b111; s0_a = 16'h00AA;
    s1_valid = 1'b1; s1_op = 3'b111; s1_a = 16'h00BB;
    for (int i = 0; i < 6; i++) begin
      exp_src = (i % 2) == 1;
      tick();
      n_tests++; if (m_valid !== 1'b1 || m_src !== exp_src || m_y !== (exp_src ? 16'h00BB : 16'h00AA)) begin
        n_fail++; $display("FAIL contention_%0d got v=%b src=%b y=%h want v=1 src=%b", i, m_valid, m_src, m_y, exp_src); end
    end
    s0_valid = 1'b0; s1_valid = 1'b0;
    n_tests++; if (cnt0 !== 16'd3 || cnt1 !== 16'd3) begin n_fail++; $display("FAIL contention_cnt got %0d/%0d want 3/3", cnt0, cnt1); end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    s0_valid = 1'b1; s0_op = 3'b111; s0_a = 16'h1234; m_ready = 1'b1;
    tick();
    s0_a = 16'h5678; m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (m_valid !== 1'b1 || m_y !== 16'h1234 || m_src !== 1'b0) begin
        n_fail++; $display("FAIL hold_%0d got v=%b y=%h src=%b want v=1 y=1234 src=0", i, m_valid, m_y, m_src); end
      n_tests++; if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready_%0d got %b%b want 00", i, s0_ready, s1_ready); end
      tick();
    end
    n_tests++; if (cnt0 !== 16'd1) begin n_fail++; $display("FAIL hold_cnt got %0d want 1", cnt0); end
    m_ready = 1'b1;
    #1;
    n_tests++; if (s0_ready !== 1'b1) begin n_fail++; $display("FAIL drain_accept_ready got %b want 1", s0_ready); end
    tick();
    s0_valid = 1'b0;
    n_tests++; if (m_valid !== 1'b1 || m_y !== 16'h5678) begin n_fail++; $display("FAIL back_to_back got v=%b y=%h want v=1 y=5678", m_valid, m_y); end
    tick();
    n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL final_drain got %b want 0", m_valid); end
  endtask

  task automatic test_saturation();
    do_reset();
    s0_valid = 1'b1; s0_op = 3'b000; s0_b = 16'h0000;
    for (int i = 0; i < 20; i++) begin
      s0_a = 16'(i);
      tick();
      if (i == 14) begin
        n_tests++; if (cnt0_4 !== 4'd15) begin n_fail++; $display("FAIL sat_reach got %0d want 15", cnt0_4); end
      end
    end
    n_tests++; if (cnt0_4 !== 4'd15) begin n_fail++; $display("FAIL sat_hold got %0d want 15", cnt0_4); end
    n_tests++; if (cnt0 !== 16'd20) begin n_fail++; $display("FAIL sat_wide got %0d want 20", cnt0); end
    s0_valid = 1'b0; m_ready = 1'b0;
    tick();
    n_tests++; if (m_valid !== 1'b1 || m_y !== 16'd19) begin n_fail++; $display("FAIL sat_held got v=%b y=%h want v=1 y=0013", m_valid, m_y); end
    rst = 1'b1;
    tick();
    rst = 1'b0; m_ready = 1'b1;
    n_tests++; if (m_valid !== 1'b0 || cnt0 !== 16'd0 || cnt0_4 !== 4'd0) begin
      n_fail++; $display("FAIL reset_mid_hold got v=%b cnt0=%0d cnt0_4=%0d want 0/0/0", m_valid, cnt0, cnt0_4); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_opsweep();
    test_contention();
    test_backpressure();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Shares one N-bit ALU datapath between two independent requesters. Each requester has a valid/ready command port.
- A round-robin arbiter picks one command per cycle and evaluates it on an internal ALU instance.
- The result is held in a single-entry output register with valid/ready backpressure, tagged with the source requester.
- Per-requester saturating grant counters are provided for debug and performance observation.

Parameters:
- N, 16, datapath width of operands and result.
- CNT_W, 16, width of each per-requester grant counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s0_valid  in  1  requester 0 command valid.
- s0_ready  out  1  requester 0 command accepted this cycle.
- s0_op  in  3  requester 0 opcode.
- s0_a  in  N  requester 0 operand a.
- s0_b  in  N  requester 0 operand b.
- s1_valid, s1_ready, s1_op, s1_a, s1_b: same as the s0_* ports, for requester 1.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts the result.
- m_y  out  N  result.
- m_op  out  3  opcode that produced m_y.
- m_src  out  1  requester index (0/1) that produced m_y.
- cnt0  out  CNT_W  accepted-command count, requester 0.
- cnt1  out  CNT_W  accepted-command count, requester 1.

Behaviour:
- Reset (rst=1 at an edge):
  - m_valid=0, m_y=0, m_op=0, m_src=0, cnt0=0, cnt1=0.
  - last_grant=1, so requester 0 wins the first contention.
  - Reset mid-hold discards the held result; no handshake completes that cycle.
- Slot free:
  - slot_free = !m_valid || m_ready.
  - Nothing is accepted when the slot is not free.
- Grant (combinational):
  - Only sK_valid asserted: grant K.
  - Both asserted: grant the requester != last_grant.
  - Neither asserted: no grant.
  - sK_ready = slot_free && grant==K. At most one ready is high per cycle.
- Handshake:
  - A command is accepted when sK_valid && sK_ready.
  - Sources must hold valid/op/a/b stable until accepted and must not make valid depend on ready.
  - ready may depend combinationally on both valids and on m_ready.
- Latency:
  - Accept at edge k, so m_valid=1 and m_y/m_op/m_src are updated after edge k.
  - This gives 1-cycle latency.
  - Full throughput of 1 result/cycle when m_ready is held 1.
- Output hold:
  - While m_valid && !m_ready, m_y/m_op/m_src stay stable and both sK_ready=0.
  - Drain with no new accept: m_valid goes to 0 next cycle.
  - Drain with a simultaneous accept: m_valid stays 1 and the new result is loaded (back-to-back).
- last_grant updates to K only on an accepted command from requester K.
- Counters: cntK increments on each accept from K and saturates at 2^CNT_W-1 (no wrap).
- ALU semantics (all results truncated to N bits):
  - 000: a+b, modulo 2^N.
  - 001: a-b, modulo 2^N.
  - 010: a&b.
  - 011: a|b.
  - 100: a^b.
  - 101: a<<1, zero fill.
  - 110: a>>1, logical.
  - 111: a (pass-through).
- No flags, no carry/overflow outputs.

Test Plan:
- Reset: assert rst 2 cycles with both valids high -> m_valid=0, m_y=0, m_src=0, cnt0=cnt1=0, s0_ready=s1_ready=0 during reset edge; first post-reset contention grants s0.
- Single requester, N=16: s0 op=000 a=0xFFFF b=0x0002, m_ready=1 -> s0_ready=1 same cycle; next cycle m_valid=1, m_y=0x0001, m_op=000, m_src=0; cnt0=1.
- Opcode sweep via s1, a=0x8001 b=0x00F0, ops 000..111 -> m_y = 0x80F1, 0x7F11, 0x0000, 0x80F1, 0x80F1, 0x0002, 0x4000, 0x8001; all m_src=1.
- Contention: both valid continuously for 6 cycles, m_ready=1 -> m_src sequence 0,1,0,1,0,1; one result per cycle; cnt0=cnt1=3.
- Backpressure: result 0x1234 pending, m_ready=0 for 3 cycles -> m_y held 0x1234, both readies 0; raise m_ready with s0 valid -> same-cycle drain+accept, m_valid stays 1, new result next cycle.
- Saturation/reset: CNT_W=4, 20 accepts from s0 -> cnt0=15; assert rst while a result is held -> m_valid=0, cnt0=0 next cycle.
